dc_fu_dma_fetch_sequencer: RTL

DC_FU_DMA_FETCH_SEQUENCER -- requirements
Module: dc_fu_dma_fetch_sequencer

---
 rtl/dc_fu_dma_fetch_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dc_fu_dma_fetch_sequencer.sv
// DMA line-fetch sequencer: splits a line request into AXI AR bursts and hands each burst to the progress counter.
// Optional DC_FU_DMA_SEQ_4K_SPLIT_EN additionally stops bursts at 4 KB address boundaries.
module dc_fu_dma_fetch_sequencer #(
    parameter int ADDR_WIDTH             = 32,
    parameter int FETCH_WORD_COUNT_WIDTH = 16,
    parameter int BYTES_PER_WORD_LOG2    = 3,
    parameter int MAX_BURST_WORDS        = 256
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              line_req_valid,
    output logic                              line_req_ready,
    input  logic [ADDR_WIDTH-1:0]             line_base_addr,
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] line_word_count,
    input  logic                              abort,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    output logic [ADDR_WIDTH-1:0]             axi_araddr,
    output logic [7:0]                        axi_arlen,
    output logic                              start_fetch,
    output logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
    input  logic                              fetch_in_progress,
    output logic                              line_done,
    output logic                              busy
);

    localparam int CW = (FETCH_WORD_COUNT_WIDTH > 13) ? FETCH_WORD_COUNT_WIDTH : 13;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                            state, state_nx;
    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] rem_q;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] fcnt_q;
    logic [8:0]                        burst_q;
    logic [7:0]                        arlen_q;
    logic                              abort_q;
    logic                              line_done_q;
    logic                              accept;
    logic                              enter_issue;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] calc_rem;
    logic [CW-1:0]                     calc_burst;
`ifdef DC_FU_DMA_SEQ_4K_SPLIT_EN
    logic [ADDR_WIDTH-1:0]             calc_addr;
    logic [12:0]                       to4k_bytes;
    logic [CW-1:0]                     to4k_words;
`endif

    // Burst size is computed for the burst about to be issued: from the request
    // inputs when leaving IDLE, from the running address/remaining otherwise.
    always_comb begin
        calc_rem   = (state == IDLE) ? line_word_count : rem_q;
        calc_burst = CW'(calc_rem);
        if (calc_burst > CW'(MAX_BURST_WORDS))
            calc_burst = CW'(MAX_BURST_WORDS);
`ifdef DC_FU_DMA_SEQ_4K_SPLIT_EN
        calc_addr  = (state == IDLE) ? line_base_addr : addr_q;
        to4k_bytes = 13'h1000 - {1'b0, calc_addr[11:0]};
        to4k_words = CW'(to4k_bytes >> BYTES_PER_WORD_LOG2);
        if (calc_burst > to4k_words)
            calc_burst = to4k_words;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        axi_arvalid = 1'b0;
        start_fetch = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (en && line_req_valid) begin
                    accept   = 1'b1;
                    state_nx = (line_word_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    start_fetch = 1'b1;
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                // A same-cycle abort also counts so that no extra AR slips out.
                if (en && !fetch_in_progress)
                    state_nx = ((rem_q == '0) || abort_q || abort) ? DONE : ISSUE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign enter_issue = (state_nx == ISSUE) && (state != ISSUE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q      <= '0;
            rem_q       <= '0;
            fcnt_q      <= '0;
            burst_q     <= '0;
            arlen_q     <= '0;
            abort_q     <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= line_base_addr;
                rem_q  <= line_word_count;
            end else if (start_fetch) begin
                addr_q <= addr_q + (ADDR_WIDTH'(burst_q) << BYTES_PER_WORD_LOG2);
                rem_q  <= rem_q - FETCH_WORD_COUNT_WIDTH'(burst_q);
                fcnt_q <= FETCH_WORD_COUNT_WIDTH'(burst_q);
            end
            if (enter_issue) begin
                burst_q <= calc_burst[8:0];
                arlen_q <= 8'(calc_burst - CW'(1));
            end
            if (state == DONE)
                abort_q <= 1'b0;
            else if (((state == ISSUE) || (state == WAIT)) && abort)
                abort_q <= 1'b1;
            line_done_q <= (state == DONE);
        end
    end

    assign line_req_ready   = (state == IDLE) && en;
    assign busy             = (state != IDLE);
    assign axi_araddr       = addr_q;
    assign axi_arlen        = arlen_q;
    assign fetch_word_count = start_fetch ? FETCH_WORD_COUNT_WIDTH'(burst_q) : fcnt_q;
    assign line_done        = line_done_q;

endmodule
